sdio_cmd_sequencer: RTL and testbench
=====================================

Name: sdio_cmd_sequencer

Overview:
- Wishbone master that drives the SD/eMMC controller's control port, turning one command request into a complete register sequence.
- Sequence per request: write ARG, write CMD, poll CMD until busy clears, read back response ARG, return status.
- Sits between a boot/init engine or soft core and the controller's Wishbone slave, so the requester never polls the controller itself.

Parameters:
- ADDR_CMD, 3'd0, controller CMD/status register address
- ADDR_ARG, 3'd1, controller argument/response register address
- BUSY_BIT, 14, bit index in CMD read data that is 1 while a command is in flight
- ERR_BIT, 15, bit index in CMD read data flagging a command error
- POLL_GAP, 16, idle cycles between consecutive status polls (0 permitted)
- LGPOLL, 16, width of poll counter; timeout after 2^LGPOLL-1 polls still busy

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  sequencer idle, accepts request
- i_req_cmd  in  32  value written to CMD register
- i_req_arg  in  32  value written to ARG register
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed
- o_rsp_status  out  32  last CMD register read value
- o_rsp_arg  out  32  ARG register value read after completion
- o_rsp_err  out  1  copy of status[ERR_BIT] at completion
- o_rsp_timeout  out  1  poll limit reached
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls
- o_wb_addr  out  3  register address
- o_wb_data  out  32  write data
- o_wb_sel  out  4  always 4'hf
- i_wb_stall, i_wb_ack  in  1 each  slave handshake
- i_wb_data  in  32  read data

Behaviour:
- Reset (async, i_reset_n low): state IDLE; o_req_ready=1; o_rsp_valid=0; o_wb_cyc=o_wb_stb=o_wb_we=0; o_wb_addr=0; o_wb_data=0; rsp fields 0; counters 0. Takes effect immediately, including mid-bus-cycle (cyc drops; controller tolerates abandoned cycle).
- o_req_ready=1 only in IDLE. Handshake i_req_valid&&o_req_ready latches cmd/arg; next cycle state WR_ARG with cyc=stb=1.
- Bus transaction rule, every state: stb held until stb&&!i_wb_stall, then stb=0, cyc held until i_wb_ack; on ack cyc=0 and state advances. Next transaction asserts cyc/stb the cycle after ack (one idle cycle minimum). Exactly one outstanding transaction. i_wb_ack while cyc=0 ignored.
- States: IDLE -> WR_ARG (we=1, addr=ADDR_ARG, data=arg) -> WR_CMD (we=1, addr=ADDR_CMD, data=cmd) -> GAP -> RD_STAT (we=0, addr=ADDR_CMD) -> CHK -> RD_ARG (we=0, addr=ADDR_ARG) -> RSP -> IDLE.
- GAP: counts POLL_GAP cycles then enters RD_STAT; POLL_GAP=0 skips GAP (RD_STAT starts cycle after WR_CMD ack).
- RD_STAT ack: status register <= i_wb_data; poll count += 1.
- CHK (1 cycle): busy bit 0 -> RD_ARG. Busy 1 and poll count == 2^LGPOLL-1 -> RSP with timeout=1, response ARG not read (o_rsp_arg=0). Otherwise -> GAP.
- RD_ARG ack: o_rsp_arg <= i_wb_data.
- RSP: o_rsp_valid=1, fields stable until i_rsp_ready; on handshake valid=0, state IDLE, poll count cleared. o_rsp_err = status[ERR_BIT]; timeout and err can both be 1.
- A new request cannot be accepted in the cycle the response completes; o_req_ready rises the following cycle.

Test Plan:
- Single command, slave never stalls, first poll returns 32'h0000_0040 -> bus sequence: W@1=arg, W@0=cmd, R@0, R@1; response status=32'h40, err=0, timeout=0, arg = readback value 32'h1234_5678.
- Stall 3 cycles on each stb, ack 2 cycles after accept -> stb held exactly while stalled, cyc held until ack, never two accepts per transaction, same response as above.
- Busy (bit14 set) on first 5 polls, clear on 6th, POLL_GAP=16 -> exactly 6 CMD reads, ≥16 idle cycles between reads, response after ARG read.
- LGPOLL=3, busy forever -> exactly 7 status reads, o_rsp_timeout=1, no ARG read, o_rsp_arg=0.
- Status 32'h0000_8000 (err, not busy) with i_rsp_ready low 10 cycles -> o_rsp_valid held 10 cycles, fields stable, o_rsp_err=1, o_req_ready=0 throughout.
- Assert i_reset_n low while stb=1 in WR_CMD -> cyc/stb drop same cycle asynchronously, o_req_ready=1 after release, next request runs full sequence cleanly.

Source files
------------

// File: rtl/sdio_cmd_sequencer.sv
// Wishbone master that runs one SD command as ARG write, CMD write, status polling, ARG readback.
// Request-to-response latency is bus-dependent; one transaction in flight, held response stalls new requests.
module sdio_cmd_sequencer #(
  parameter logic [2:0] ADDR_CMD = 3'd0,
  parameter logic [2:0] ADDR_ARG = 3'd1,
  parameter int         BUSY_BIT = 14,
  parameter int         ERR_BIT  = 15,
  parameter int         POLL_GAP = 16,
  parameter int         LGPOLL   = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_cmd,
  input  logic [31:0] i_req_arg,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_status,
  output logic [31:0] o_rsp_arg,
  output logic        o_rsp_err,
  output logic        o_rsp_timeout,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ARG, S_WR_CMD, S_GAP, S_RD_STAT, S_CHK, S_RD_ARG, S_RSP
  } state_t;

  localparam int                GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0]     GAP_LAST = GW'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);
  localparam logic [LGPOLL-1:0] POLL_MAX = '1;

  state_t              state_q, state_d;
  logic [31:0]         cmd_q, cmd_d;
  logic [31:0]         arg_q, arg_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [2:0]          addr_q, addr_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [LGPOLL-1:0]   poll_cnt_q, poll_cnt_d;
  logic [31:0]         status_q, status_d;
  logic [31:0]         rsp_arg_q, rsp_arg_d;
  logic                timeout_q, timeout_d;

  // Per-state bus transaction descriptor
  logic        in_bus;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdat;
  logic        xact_done;

  always_comb begin
    in_bus   = 1'b0;
    bus_we   = 1'b0;
    bus_addr = 3'd0;
    bus_wdat = 32'd0;
    case (state_q)
      S_WR_ARG:  begin in_bus = 1'b1; bus_we = 1'b1; bus_addr = ADDR_ARG; bus_wdat = arg_q; end
      S_WR_CMD:  begin in_bus = 1'b1; bus_we = 1'b1; bus_addr = ADDR_CMD; bus_wdat = cmd_q; end
      S_RD_STAT: begin in_bus = 1'b1; bus_addr = ADDR_CMD; end
      S_RD_ARG:  begin in_bus = 1'b1; bus_addr = ADDR_ARG; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    gap_cnt_d  = gap_cnt_q;
    poll_cnt_d = poll_cnt_q;
    status_d   = status_q;
    rsp_arg_d  = rsp_arg_q;
    timeout_d  = timeout_q;
    xact_done  = 1'b0;

    // cyc low inside a bus state means the previous cycle ended one; launch now, leaving one idle cycle
    if (in_bus) begin
      if (!cyc_q) begin
        cyc_d  = 1'b1;
        stb_d  = 1'b1;
        we_d   = bus_we;
        addr_d = bus_addr;
        wdat_d = bus_wdat;
      end else begin
        if (stb_q && !i_wb_stall) stb_d = 1'b0;
        if (i_wb_ack) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          xact_done = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          cmd_d     = i_req_cmd;
          arg_d     = i_req_arg;
          rsp_arg_d = 32'd0;
          timeout_d = 1'b0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b1;
          addr_d    = ADDR_ARG;
          wdat_d    = i_req_arg;
          state_d   = S_WR_ARG;
        end
      end
      S_WR_ARG: if (xact_done) state_d = S_WR_CMD;
      S_WR_CMD: begin
        if (xact_done) begin
          gap_cnt_d = '0;
          state_d   = (POLL_GAP == 0) ? S_RD_STAT : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_RD_STAT;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      S_RD_STAT: begin
        if (xact_done) begin
          status_d   = i_wb_data;
          poll_cnt_d = poll_cnt_q + 1'b1;
          state_d    = S_CHK;
        end
      end
      S_CHK: begin
        if (!status_q[BUSY_BIT]) begin
          state_d = S_RD_ARG;
        end else if (poll_cnt_q == POLL_MAX) begin
          timeout_d = 1'b1;
          state_d   = S_RSP;
        end else begin
          gap_cnt_d = '0;
          state_d   = (POLL_GAP == 0) ? S_RD_STAT : S_GAP;
        end
      end
      S_RD_ARG: begin
        if (xact_done) begin
          rsp_arg_d = i_wb_data;
          state_d   = S_RSP;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          poll_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 32'd0;
      arg_q      <= 32'd0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 3'd0;
      wdat_q     <= 32'd0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      status_q   <= 32'd0;
      rsp_arg_q  <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      status_q   <= status_d;
      rsp_arg_q  <= rsp_arg_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_req_ready   = (state_q == S_IDLE);
  assign o_rsp_valid   = (state_q == S_RSP);
  assign o_rsp_status  = status_q;
  assign o_rsp_arg     = rsp_arg_q;
  assign o_rsp_err     = status_q[ERR_BIT];
  assign o_rsp_timeout = timeout_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = we_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = wdat_q;
  assign o_wb_sel      = 4'hf;

endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// Bench for sdio_cmd_sequencer: table of command scenarios against a behavioural Wishbone slave,
// plus a mid-transaction reset sequence.
module tb_sdio_cmd_sequencer;

  localparam int PGAP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_cmd = 32'd0;
  logic [31:0] req_arg = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_status, rsp_arg;
  logic        rsp_err, rsp_timeout;
  logic        wb_cyc, wb_stb, wb_we;
  logic [2:0]  wb_addr;
  logic [31:0] wb_wdat;
  logic [3:0]  wb_sel;
  logic        wb_stall = 1'b0;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_rdat = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  sdio_cmd_sequencer #(.POLL_GAP(PGAP), .LGPOLL(3)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_cmd(req_cmd), .i_req_arg(req_arg),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_status(rsp_status), .o_rsp_arg(rsp_arg),
    .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdat), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave configuration and transaction log
  int          stall_cycles = 0, ack_delay = 1, busy_polls = 0;
  logic [31:0] busy_val = 32'h0, final_val = 32'h0, arg_rd = 32'h0;
  logic        log_we[64];
  logic [2:0]  log_addr[64];
  logic [31:0] log_dat[64];
  int          log_t[64];
  int          log_n = 0, cmd_rd_n = 0, viol = 0, cyc_n = 0;
  int          stall_cnt = 0, ack_cnt = 0;
  logic        pend = 1'b0, acc = 1'b0;
  logic [31:0] pend_dat = 32'h0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    wb_ack  = 1'b0;
    wb_rdat = 32'hDEAD_BEEF;
    if (!wb_cyc) begin
      if (rst_n && pend) viol++;
      pend = 1'b0; acc = 1'b0; stall_cnt = 0; wb_stall = 1'b0;
    end else begin
      if (pend) begin
        if (ack_cnt <= 1) begin
          wb_ack = 1'b1; wb_rdat = pend_dat; pend = 1'b0;
        end else ack_cnt--;
      end
      if (wb_stb) begin
        if (acc) begin
          viol++;
        end else if (stall_cnt < stall_cycles) begin
          wb_stall = 1'b1; stall_cnt++;
        end else begin
          wb_stall = 1'b0; acc = 1'b1; pend = 1'b1; ack_cnt = ack_delay;
          if (wb_sel != 4'hf) viol++;
          if (log_n < 64) begin
            log_we[log_n] = wb_we; log_addr[log_n] = wb_addr;
            log_dat[log_n] = wb_wdat; log_t[log_n] = cyc_n; log_n++;
          end
          if (wb_we) pend_dat = 32'h0;
          else if (wb_addr == 3'd0) begin
            pend_dat = (cmd_rd_n < busy_polls) ? busy_val : final_val;
            cmd_rd_n++;
          end else pend_dat = arg_rd;
        end
      end else begin
        wb_stall = 1'b0;
        if (!acc) viol++;
      end
    end
  end

  typedef struct {
    logic [31:0] cmd, arg;
    int          stall, dly, busy_n;
    logic [31:0] busy_v, final_v, arg_v;
    int          hold, exp_reads;
    logic [31:0] exp_status;
    logic        exp_err, exp_to;
    logic [31:0] exp_arg;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int i);
    vec_t v;
    logic [31:0] st, ra;
    logic er, to, stable, seq_ok, gap_ok;
    int exp_n, nreads;
    v = vecs[i];
    stall_cycles = v.stall; ack_delay = v.dly; busy_polls = v.busy_n;
    busy_val = v.busy_v; final_val = v.final_v; arg_rd = v.arg_v;
    log_n = 0; cmd_rd_n = 0; viol = 0;
    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", i), req_ready, 1);
    req_valid = 1'b1; req_cmd = v.cmd; req_arg = v.arg;
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("v%0d_ready_busy", i), req_ready, 0);
    for (int c = 0; c < 3000 && !rsp_valid; c++) @(negedge clk);
    chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
    st = rsp_status; ra = rsp_arg; er = rsp_err; to = rsp_timeout;
    chk($sformatf("v%0d_status", i), st, v.exp_status);
    chk($sformatf("v%0d_err", i), er, v.exp_err);
    chk($sformatf("v%0d_timeout", i), to, v.exp_to);
    chk($sformatf("v%0d_arg", i), ra, v.exp_arg);
    stable = 1'b1;
    for (int c = 0; c < v.hold; c++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_status !== st || rsp_arg !== ra ||
          rsp_err !== er || rsp_timeout !== to) stable = 1'b0;
    end
    if (v.hold > 0) chk($sformatf("v%0d_hold", i), stable, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_valid_after", i), rsp_valid, 0);
    chk($sformatf("v%0d_ready_after", i), req_ready, 1);
    exp_n = 2 + v.exp_reads + (v.exp_to ? 0 : 1);
    chk($sformatf("v%0d_ntrans", i), log_n, exp_n);
    nreads = 0;
    seq_ok = (log_n == exp_n);
    gap_ok = 1'b1;
    for (int k = 0; k < log_n; k++) begin
      if (!log_we[k] && log_addr[k] == 3'd0) begin
        nreads++;
        if (k > 2 && log_t[k] - log_t[k-1] <= PGAP) gap_ok = 1'b0;
      end
      if (k == 0 && !(log_we[k] && log_addr[k] == 3'd1 && log_dat[k] == v.arg)) seq_ok = 1'b0;
      if (k == 1 && !(log_we[k] && log_addr[k] == 3'd0 && log_dat[k] == v.cmd)) seq_ok = 1'b0;
      if (k >= 2 && k < 2 + v.exp_reads && !(!log_we[k] && log_addr[k] == 3'd0)) seq_ok = 1'b0;
      if (k == 2 + v.exp_reads && !(!log_we[k] && log_addr[k] == 3'd1)) seq_ok = 1'b0;
    end
    chk($sformatf("v%0d_nreads", i), nreads, v.exp_reads);
    chk($sformatf("v%0d_seq", i), seq_ok, 1);
    if (v.exp_reads > 1) chk($sformatf("v%0d_gap", i), gap_ok, 1);
    if (log_n >= 2) chk($sformatf("v%0d_wspace", i), (log_t[1] - log_t[0] >= v.dly + 2), 1);
    chk($sformatf("v%0d_proto", i), viol, 0);
  endtask

  initial begin
    logic found;
    //          cmd           arg           stl dly busyN busy_v        final_v       arg_v         hold rds status        err   to    arg
    vecs[0] = '{32'h0000_0011, 32'hA5A5_0001, 0, 1, 0,   32'h0000_4040, 32'h0000_0040, 32'h1234_5678, 0, 1, 32'h0000_0040, 1'b0, 1'b0, 32'h1234_5678};
    vecs[1] = '{32'h0000_0022, 32'h5A5A_0002, 3, 2, 0,   32'h0000_4040, 32'h0000_0040, 32'h1234_5678, 0, 1, 32'h0000_0040, 1'b0, 1'b0, 32'h1234_5678};
    vecs[2] = '{32'h0000_0033, 32'h0BAD_F00D, 0, 1, 5,   32'h0000_4040, 32'h0000_0040, 32'h1234_5678, 0, 6, 32'h0000_0040, 1'b0, 1'b0, 32'h1234_5678};
    vecs[3] = '{32'h0000_0044, 32'hCAFE_0004, 0, 1, 100, 32'h0000_4000, 32'h0000_0040, 32'h1234_5678, 0, 7, 32'h0000_4000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_0055, 32'hCAFE_0005, 1, 1, 100, 32'h0000_C000, 32'h0000_0040, 32'h1234_5678, 0, 7, 32'h0000_C000, 1'b1, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'h0000_0066, 32'hBEEF_0006, 0, 1, 0,   32'h0000_4040, 32'h0000_8000, 32'h8765_4321, 10, 1, 32'h0000_8000, 1'b1, 1'b0, 32'h8765_4321};

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_wdata", wb_wdat, 0);
    chk("rst_sel", wb_sel, 4'hf);
    chk("rst_rsp_fields", {rsp_status, rsp_arg, rsp_err, rsp_timeout} == '0, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", req_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset while the CMD write is strobing into a stalled slave
    stall_cycles = 40; ack_delay = 1; busy_polls = 0; log_n = 0; cmd_rd_n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 32'h0000_0077; req_arg = 32'h7777_0007;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (wb_stb && wb_we && wb_addr == 3'd0) found = 1'b1;
    end
    chk("rstmid_in_wrcmd", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cyc", wb_cyc, 0);
    chk("rstmid_stb", wb_stb, 0);
    chk("rstmid_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_after", req_ready, 1);
    chk("rstmid_valid_after", rsp_valid, 0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
